// File: rtl/msk_piso_pkg.sv
// Shared types and sizing helpers for the masked PISO unloader.
package msk_piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int D_DEF     = 2;
  localparam int COUNT_DEF = 4;
  localparam int N_DEF     = 8;
  localparam int ELEM_W    = COUNT_DEF * D_DEF;

  // Element index width; a single-element load still needs one bit.
  function automatic int idx_width(input int num);
    return (num <= 1) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/msk_piso_unloader_stage.sv
// One masked element slot: share-wise load/shift/hold mux into a register.
module msk_piso_unloader_stage
  import msk_piso_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_shift_val,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Selects are unmasked control; every bit picks only its own share.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= i_shift_val;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/msk_piso_unloader.sv
// Masked parallel-in/serial-out unloader: one wide word in, n masked elements out.
module msk_piso_unloader
  import msk_piso_pkg::*;
#(
  parameter int d     = D_DEF,
  parameter int count = COUNT_DEF,
  parameter int n     = N_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [n*count*d-1:0]   in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [count*d-1:0]     out,
  output logic                   out_last,
  output state_t                 o_dbg_state
);

  localparam int EW = count * d;
  localparam int IW = idx_width(n);
  localparam logic [IW-1:0] LAST_IDX = IW'(n - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          w_accept;
  logic          w_load;
  logic          w_shift;
  logic [EW-1:0] w_slot_q  [n];
  logic [EW-1:0] w_shift_in[n];

  genvar k;
  generate
    for (k = 0; k < n; k++) begin : g_slot
      if (k == n - 1) begin : g_top
        assign w_shift_in[k] = '0;
      end else begin : g_mid
        assign w_shift_in[k] = w_slot_q[k+1];
      end
      msk_piso_unloader_stage #(.W(EW)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_load_val (in[k*EW +: EW]),
        .i_shift_val(w_shift_in[k]),
        .o_q        (w_slot_q[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // A transfer happens on any edge where valid and ready are both high;
  // the final element's transfer also reopens the input for a same-edge reload.
  always_comb begin
    out_valid   = (r_state == SHIFT);
    out_last    = out_valid && (r_idx == LAST_IDX);
    w_accept    = out_valid && out_ready;
    in_ready    = (r_state == IDLE) || (w_accept && out_last);
    w_load      = in_valid && in_ready;
    w_shift     = w_accept && !out_last;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_load) begin
      w_state_nxt = SHIFT;
      w_idx_nxt   = '0;
    end else if (w_accept && out_last) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else if (w_shift) begin
      w_idx_nxt   = r_idx + 1'b1;
    end
  end

  assign out         = w_slot_q[0];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_msk_piso_unloader.sv
// Self-checking bench for msk_piso_unloader (n=3 main instance, n=1 side instance).
module tb_msk_piso_unloader;
  import msk_piso_pkg::*;

  localparam int D   = 2;
  localparam int CNT = 4;
  localparam int N   = 3;
  localparam int EW  = CNT * D;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*EW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [EW-1:0]   out_data;
  logic            out_last;
  state_t          dbg;

  logic            in_valid1;
  logic            in_ready1;
  logic [EW-1:0]   in_data1;
  logic            out_valid1;
  logic            out_ready1;
  logic [EW-1:0]   out_data1;
  logic            out_last1;
  state_t          dbg1;

  int checks   = 0;
  int failures = 0;
  logic [7:0] lfsr = 8'h01;
  logic [EW:0] exp_q[$];
  logic [EW:0] exp1_q[$];

  always #5 clk = ~clk;

  msk_piso_unloader #(.d(D), .count(CNT), .n(N)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_data), .out_last(out_last),
    .o_dbg_state(dbg)
  );

  msk_piso_unloader #(.d(D), .count(CNT), .n(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out(out_data1), .out_last(out_last1),
    .o_dbg_state(dbg1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mask_elem(input logic [CNT-1:0] v, input logic [CNT-1:0] s0);
    logic [EW-1:0] e;
    for (int b = 0; b < CNT; b++) begin
      e[b*D]   = s0[b];
      e[b*D+1] = v[b] ^ s0[b];
    end
    return e;
  endfunction

  // Scoreboard: pop on each output transfer, then push any word loaded at the same edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          logic [EW:0] e;
          e = exp_q.pop_front();
          check("sb_elem", 32'(out_data), 32'(e[EW-1:0]));
          check("sb_last", 32'(out_last), 32'(e[EW]));
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), in_data[k*EW +: EW]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid1) check("n1_last", 32'(out_last1), 32'd1);
      if (out_valid1 && out_ready1) begin
        if (exp1_q.size() == 0) begin
          check("n1_unexpected_beat", 32'(out_data1), 32'hFFFF_FFFF);
        end else begin
          logic [EW:0] e;
          e = exp1_q.pop_front();
          check("n1_elem", 32'(out_data1), 32'(e[EW-1:0]));
        end
      end
      if (in_valid1 && in_ready1) exp1_q.push_back({1'b1, in_data1});
    end
  end

  task automatic send_word(input logic [N*CNT-1:0] vals, output logic in_shift);
    bit got = 0;
    in_shift = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      in_data[k*EW +: EW] = mask_elem(vals[k*CNT +: CNT], lfsr[3:0]);
    end
    in_valid = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        in_shift = (dbg == SHIFT);
      end
    end
    if (!got) check("load_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("first_valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!out_valid) done = 1;
    end
    check("drain_idle_valid", 32'(out_valid), 32'd0);
    check("drain_idle_state", 32'(dbg), 32'(IDLE));
  endtask

  typedef struct {
    logic [N*CNT-1:0] vals;
    int               stall;
  } vec_t;

  vec_t tab[4];

  initial begin
    logic sh;
    tab[0] = '{vals: {4'h3, 4'hA, 4'h5}, stall: 0};
    tab[1] = '{vals: {4'h3, 4'hA, 4'h5}, stall: 4};
    tab[2] = '{vals: {4'hC, 4'h0, 4'hF}, stall: 0};
    tab[3] = '{vals: 12'($urandom), stall: 2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_zero", 32'(out_data), 32'd0);
    check("rst_state", 32'(dbg), 32'(IDLE));
    check("rst_n1_out_zero", 32'(out_data1), 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_word(tab[i].vals, sh);
      if (tab[i].stall > 0) begin
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = (N*EW)'($urandom);
        for (int s = 0; s < tab[i].stall; s++) begin
          @(negedge clk);
          check("stall_hold", 32'(out_data), 32'(exp_q[0][EW-1:0]));
          check("stall_last", 32'(out_last), 32'd0);
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      drain();
    end

    send_word({4'h3, 4'hA, 4'h5}, sh);
    send_word({4'h7, 4'h2, 4'h1}, sh);
    check("b2b_no_bubble", 32'(sh), 32'd1);
    drain();

    send_word({4'h9, 4'h6, 4'hE}, sh);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_zero", 32'(out_data), 32'd0);
    send_word({4'hB, 4'h4, 4'h8}, sh);
    drain();

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid1  = 1'b1;
      in_data1   = EW'($urandom);
      out_ready1 = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    check("n1_drained", 32'(out_valid1), 32'd0);
    check("n1_queue_empty", 32'(exp1_q.size()), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
